wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and data width.
REQ-002 SHALL have parameter REG_CNT, default 32: number of architectural registers.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5: register address width, equal to clog2(REG_CNT).
REQ-004 SHALL have parameter LD_FIFO_DEPTH, default 4: load-return buffer entries, a power of 2 and at least 2.
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have ports alu_valid in 1, alu_rd in REG_ADDR_WIDTH, alu_val in XLEN: ALU/LUI/JAL result channel; it is always accepted.
REQ-008 SHALL have ports ld_valid in 1, ld_rd in REG_ADDR_WIDTH, ld_funct3 in 3, ld_offset in 2, ld_data in XLEN, ld_ready out 1: load-return channel.
REQ-009 SHALL have ports iss_valid in 1, iss_rd in REG_ADDR_WIDTH: issue notification that marks rd pending.
REQ-010 SHALL have ports rs1_addr, rs2_addr in REG_ADDR_WIDTH; rs1_val, rs2_val out XLEN; rs1_busy, rs2_busy out 1: read ports.
REQ-011 SHALL have ports wb_valid out 1, wb_rd out REG_ADDR_WIDTH: registered record of the previous cycle's committed write.

Function
REQ-012 SHALL commit at most one register write per cycle; ALU channel has priority over the FIFO head.
REQ-013 SHALL accept a load beat when ld_valid and ld_ready are both 1, pushing {rd, funct3, offset, data}.
REQ-014 SHALL drive ld_ready = !full, combinational from the FIFO count only.
REQ-015 SHALL pop the FIFO head and write it in any cycle where the FIFO is non-empty and alu_valid is 0.
REQ-016 SHALL accept a push and a pop in the same cycle when the FIFO is full; count is unchanged and ld_ready stays 0 for that cycle.
REQ-017 SHALL wrap read and write pointers modulo LD_FIFO_DEPTH and track count in clog2(LD_FIFO_DEPTH)+1 bits.
REQ-018 SHALL align load data as shifted = ld_data >> (8*offset).
REQ-019 SHALL format load data by funct3 as follows.
- 000 (LB): sign-extend shifted[7:0].
- 100 (LBU): zero-extend shifted[7:0].
- 001 (LH): sign-extend shifted[15:0].
- 101 (LHU): zero-extend shifted[15:0].
- 010 (LW): write shifted unchanged.
- Any other funct3: no write, and the busy bit is still cleared.
REQ-020 SHALL write the full XLEN value for ALU writes; there is no partial-field write.
REQ-021 SHALL never write x0; x0 always reads 0 and is never busy.
REQ-022 SHALL set busy[iss_rd] on iss_valid (rd != 0) and clear busy[rd] on commit of a write to rd.
REQ-023 SHALL give set priority over clear when both target the same rd in one cycle.
REQ-024 SHALL drive rsN_val combinationally and forward the value being committed this cycle when its rd equals rsN_addr (nonzero).
REQ-025 SHALL drive rsN_busy = busy[rsN_addr] & !(commit this cycle to rsN_addr).
REQ-026 SHALL register wb_valid/wb_rd one cycle after commit; a dropped-funct3 pop gives wb_valid=0.
REQ-027 SHALL be fully synthesizable, with no latches and no combinational path from ld_valid to ld_ready.

Reset
REQ-028 SHALL, while rst=1, hold all registers at 0, all busy bits at 0, the FIFO empty (pointers and count 0), wb_valid=0, wb_rd=0, and ld_ready=1.
REQ-029 SHALL discard FIFO contents and pending busy bits when rst asserts mid-operation; there is no partial write after rst deasserts.

Verification
REQ-030 SHALL cover: alu_valid, rd=5, val=0xDEADBEEF -> rs1_addr=5 reads 0xDEADBEEF the same cycle (forward) and the next cycle; wb_valid=1, wb_rd=5 one cycle later.
REQ-031 SHALL cover: ld_data=0x80FF7F01, offset=2, funct3=000 (LB), rd=3 -> x3=0xFFFFFFFF; same with funct3=100 (LBU) -> 0x000000FF; funct3=001 (LH), offset=2 -> 0xFFFF80FF.
REQ-032 SHALL cover: alu_valid held 1 for 6 cycles with 5 load beats offered -> ld_ready falls to 0 after 4 accepts; the FIFO drains in order at 1 per cycle once alu_valid drops.
REQ-033 SHALL cover: iss_valid rd=7, then a load to rd 7 -> rs1_busy=1 until the commit cycle, 0 that cycle (forwarded); simultaneous iss rd=7 and commit rd=7 -> busy stays 1.
REQ-034 SHALL cover: write to x0 via ALU and via load -> x0 reads 0, wb_valid=0, and the busy bit for x0 is never set.
REQ-035 SHALL cover: rst asserted with 3 FIFO entries and 2 busy regs -> the next cycle shows count=0, ld_ready=1, all busy 0, and all registers 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - writeback / register-read bundle for wb_regfile
interface wb_regfile_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      alu_valid;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [XLEN-1:0]           alu_val;

    logic                      ld_valid;
    logic [REG_ADDR_WIDTH-1:0] ld_rd;
    logic [2:0]                ld_funct3;
    logic [1:0]                ld_offset;
    logic [XLEN-1:0]           ld_data;
    logic                      ld_ready;

    logic                      iss_valid;
    logic [REG_ADDR_WIDTH-1:0] iss_rd;

    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [XLEN-1:0]           rs1_val;
    logic [XLEN-1:0]           rs2_val;
    logic                      rs1_busy;
    logic                      rs2_busy;

    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;

    modport master (
        output alu_valid, alu_rd, alu_val,
        output ld_valid, ld_rd, ld_funct3, ld_offset, ld_data,
        input  ld_ready,
        output iss_valid, iss_rd,
        output rs1_addr, rs2_addr,
        input  rs1_val, rs2_val, rs1_busy, rs2_busy,
        input  wb_valid, wb_rd
    );

    modport slave (
        input  alu_valid, alu_rd, alu_val,
        input  ld_valid, ld_rd, ld_funct3, ld_offset, ld_data,
        output ld_ready,
        input  iss_valid, iss_rd,
        input  rs1_addr, rs2_addr,
        output rs1_val, rs2_val, rs1_busy, rs2_busy,
        output wb_valid, wb_rd
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - register file with ALU/load writeback, load-return FIFO and busy scoreboard
module wb_regfile #(
    parameter int XLEN           = 32,
    parameter int REG_CNT        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LD_FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);
    localparam int PTR_W = $clog2(LD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LD_FIFO_DEPTH);

    logic [XLEN-1:0]           regs [REG_CNT];
    logic [REG_CNT-1:0]        busy;
    logic [REG_CNT-1:0]        busy_next;

    logic [REG_ADDR_WIDTH-1:0] fifo_rd   [LD_FIFO_DEPTH];
    logic [2:0]                fifo_f3   [LD_FIFO_DEPTH];
    logic [1:0]                fifo_off  [LD_FIFO_DEPTH];
    logic [XLEN-1:0]           fifo_data [LD_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic [XLEN-1:0]           shifted;
    logic [XLEN-1:0]           load_val;
    logic                      load_ok;
    logic                      clr_en;
    logic [REG_ADDR_WIDTH-1:0] clr_rd;
    logic [XLEN-1:0]           commit_val;
    logic                      commit_we;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // ALU results always win the single write port; the FIFO head drains otherwise.
    assign pop   = !empty && !bus.alu_valid;
    // A full FIFO that is draining this cycle still has room for one incoming beat.
    assign push  = bus.ld_valid && (!full || pop);
    assign bus.ld_ready = !full;

    assign shifted = fifo_data[rd_ptr] >> {fifo_off[rd_ptr], 3'b000};

    // Extract and extend the loaded field; unknown encodings are dropped.
    always_comb begin
        load_val = '0;
        load_ok  = 1'b0;
        case (fifo_f3[rd_ptr])
            3'b000: begin load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};    load_ok = 1'b1; end
            3'b100: begin load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};          load_ok = 1'b1; end
            3'b001: begin load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]}; load_ok = 1'b1; end
            3'b101: begin load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};        load_ok = 1'b1; end
            3'b010: begin load_val = shifted;                                   load_ok = 1'b1; end
            default: begin load_val = '0; load_ok = 1'b0; end
        endcase
    end

    // Select this cycle's commit; a dropped load still retires its rd from the scoreboard.
    always_comb begin
        clr_en     = bus.alu_valid || pop;
        clr_rd     = bus.alu_valid ? bus.alu_rd  : fifo_rd[rd_ptr];
        commit_val = bus.alu_valid ? bus.alu_val : load_val;
        commit_we  = (bus.alu_valid || (pop && load_ok)) && (clr_rd != '0);
    end

    // Read ports with same-cycle forwarding of the committing value.
    always_comb begin
        bus.rs1_val = regs[bus.rs1_addr];
        bus.rs2_val = regs[bus.rs2_addr];
        if (commit_we && clr_rd == bus.rs1_addr) bus.rs1_val = commit_val;
        if (commit_we && clr_rd == bus.rs2_addr) bus.rs2_val = commit_val;
        if (bus.rs1_addr == '0) bus.rs1_val = '0;
        if (bus.rs2_addr == '0) bus.rs2_val = '0;
        bus.rs1_busy = busy[bus.rs1_addr] && !(clr_en && clr_rd == bus.rs1_addr);
        bus.rs2_busy = busy[bus.rs2_addr] && !(clr_en && clr_rd == bus.rs2_addr);
    end

    // Scoreboard update: clear on retire, then set on issue so issue wins a tie.
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_rd] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != '0) busy_next[bus.iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Architectural register array; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (commit_we) begin
            regs[clr_rd] <= commit_val;
        end
    end

    // Busy bits, FIFO pointers/count and writeback record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_rd    <= '0;
        end else begin
            busy <= busy_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            bus.wb_valid <= commit_we;
            bus.wb_rd    <= commit_we ? clr_rd : '0;
        end
    end

    // Load-return payload storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.ld_rd;
            fifo_f3[wr_ptr]   <= bus.ld_funct3;
            fifo_off[wr_ptr]  <= bus.ld_offset;
            fifo_data[wr_ptr] <= bus.ld_data;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wb_regfile_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) bus ();

    wb_regfile #(
        .XLEN(32), .REG_CNT(32), .REG_ADDR_WIDTH(5), .LD_FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] data);
        bus.ld_valid  = v;
        bus.ld_rd     = rd;
        bus.ld_funct3 = f3;
        bus.ld_offset = off;
        bus.ld_data   = data;
    endtask

    // Push one beat into an empty FIFO, let it pop, then read the register back.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] data,
                           input logic [31:0] exp_val, input logic exp_wb);
        set_ld(1'b1, rd, f3, off, data);
        tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        tick();
        bus.rs2_addr = rd;
        #1;
        chk({tag, "_val"}, bus.rs2_val, exp_val);
        chk({tag, "_wbv"}, {31'd0, bus.wb_valid}, {31'd0, exp_wb});
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_val = '0;
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;

        // Reset state
        tick(); tick();
        chk("rst_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("rst_wbv",   {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wbrd",  {27'd0, bus.wb_rd}, 32'd0);
        chk("rst_x5",    bus.rs1_val, 32'd0);
        chk("rst_busy",  {31'd0, bus.rs1_busy}, 32'd0);
        rst = 1'b0;
        tick();

        // ALU write with forwarding
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_val = 32'hDEADBEEF;
        #1;
        chk("alu_fwd", bus.rs1_val, 32'hDEADBEEF);
        chk("alu_wbv_pre", {31'd0, bus.wb_valid}, 32'd0);
        tick();
        bus.alu_valid = 1'b0;
        #1;
        chk("alu_reg", bus.rs1_val, 32'hDEADBEEF);
        chk("alu_wbv", {31'd0, bus.wb_valid}, 32'd1);
        chk("alu_wbrd", {27'd0, bus.wb_rd}, 32'd5);
        tick();
        chk("alu_wbv_post", {31'd0, bus.wb_valid}, 32'd0);

        // Load formatting
        do_load("lb",  5'd3, 3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF, 1'b1);
        do_load("lbu", 5'd3, 3'b100, 2'd2, 32'h80FF7F01, 32'h000000FF, 1'b1);
        do_load("lh",  5'd3, 3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF, 1'b1);
        do_load("lhu", 5'd4, 3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF, 1'b1);
        do_load("lw",  5'd4, 3'b010, 2'd0, 32'h80FF7F01, 32'h80FF7F01, 1'b1);
        do_load("lb1", 5'd6, 3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F, 1'b1);
        // Unknown funct3: no write, busy still cleared
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        tick();
        bus.iss_valid = 1'b0;
        do_load("bad", 5'd3, 3'b011, 2'd0, 32'h12345678, 32'hFFFF80FF, 1'b0);
        chk("bad_busy", {31'd0, bus.rs2_busy}, 32'd0);

        // Scoreboard with a pending load
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        tick();
        bus.iss_valid = 1'b0;
        bus.rs1_addr = 5'd7;
        set_ld(1'b1, 5'd7, 3'b010, 2'd0, 32'h12345678);
        #1;
        chk("sb_busy_wait", {31'd0, bus.rs1_busy}, 32'd1);
        tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        #1;
        chk("sb_busy_commit", {31'd0, bus.rs1_busy}, 32'd0);
        chk("sb_fwd", bus.rs1_val, 32'h12345678);
        tick();
        chk("sb_busy_after", {31'd0, bus.rs1_busy}, 32'd0);
        chk("sb_wbrd", {27'd0, bus.wb_rd}, 32'd7);
        // Issue and commit to the same rd in one cycle: set wins
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_val = 32'h00000077;
        tick();
        bus.iss_valid = 1'b0; bus.alu_valid = 1'b0;
        #1;
        chk("sb_set_wins", {31'd0, bus.rs1_busy}, 32'd1);
        chk("sb_val77", bus.rs1_val, 32'h00000077);

        // x0 is never written or busy
        bus.rs1_addr = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_val = 32'hFFFFFFFF;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        #1;
        chk("x0_fwd", bus.rs1_val, 32'd0);
        tick();
        bus.alu_valid = 1'b0; bus.iss_valid = 1'b0;
        #1;
        chk("x0_alu_wbv", {31'd0, bus.wb_valid}, 32'd0);
        chk("x0_busy", {31'd0, bus.rs1_busy}, 32'd0);
        do_load("x0_ld", 5'd0, 3'b010, 2'd0, 32'hCAFEF00D, 32'd0, 1'b0);

        // FIFO fill under ALU pressure, then in-order drain
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9;
        for (int i = 0; i < 6; i++) begin
            bus.alu_val = 32'h9000 + i;
            if (i < 5) set_ld(1'b1, 5'(10 + i), 3'b010, 2'd0, 32'hA000_0000 + i);
            else       set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
            #1;
            chk($sformatf("fill_ready%0d", i), {31'd0, bus.ld_ready}, (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rs1_addr = 5'(10 + i);
            #1;
            chk($sformatf("drain_fwd%0d", i), bus.rs1_val, 32'hA000_0000 + i);
            chk($sformatf("drain_ready%0d", i), {31'd0, bus.ld_ready}, (i == 0) ? 32'd0 : 32'd1);
            tick();
            chk($sformatf("drain_wbrd%0d", i), {27'd0, bus.wb_rd}, 32'(10 + i));
        end
        bus.rs1_addr = 5'd14; bus.rs2_addr = 5'd9;
        #1;
        chk("drain_x14", bus.rs1_val, 32'd0);
        chk("drain_x9", bus.rs2_val, 32'h9005);

        // Push and pop together while full
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_val = 32'h1;
        for (int i = 0; i < 4; i++) begin
            set_ld(1'b1, 5'(16 + i), 3'b010, 2'd0, 32'hB000_0000 + i);
            tick();
        end
        bus.alu_valid = 1'b0;
        set_ld(1'b1, 5'd20, 3'b010, 2'd0, 32'hB000_0004);
        #1;
        chk("full_ready", {31'd0, bus.ld_ready}, 32'd0);
        tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        #1;
        chk("full_ready_hold", {31'd0, bus.ld_ready}, 32'd0);
        chk("full_wbrd0", {27'd0, bus.wb_rd}, 32'd16);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("full_wbrd%0d", i), {27'd0, bus.wb_rd}, 32'(16 + i));
        end
        bus.rs1_addr = 5'd20;
        #1;
        chk("full_x20", bus.rs1_val, 32'hB000_0004);

        // Reset mid-operation: 3 FIFO entries, 2 busy regs
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_val = 32'h2;
        bus.iss_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.iss_rd = (i == 0) ? 5'd21 : 5'd22;
            set_ld(1'b1, 5'd23, 3'b010, 2'd0, 32'hC000_0000 + i);
            tick();
        end
        bus.iss_valid = 1'b0; bus.alu_valid = 1'b0;
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        rst = 1'b1;
        tick();
        bus.rs1_addr = 5'd21; bus.rs2_addr = 5'd22;
        #1;
        chk("mrst_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("mrst_busy21", {31'd0, bus.rs1_busy}, 32'd0);
        chk("mrst_busy22", {31'd0, bus.rs2_busy}, 32'd0);
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd9;
        #1;
        chk("mrst_x5", bus.rs1_val, 32'd0);
        chk("mrst_x9", bus.rs2_val, 32'd0);
        rst = 1'b0;
        tick(); tick();
        bus.rs1_addr = 5'd23;
        #1;
        chk("mrst_nowb", {31'd0, bus.wb_valid}, 32'd0);
        chk("mrst_x23", bus.rs1_val, 32'd0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_val = 32'h3;
        for (int i = 0; i < 5; i++) begin
            set_ld(1'b1, 5'd24, 3'b010, 2'd0, 32'hD000_0000 + i);
            #1;
            chk($sformatf("mrst_refill%0d", i), {31'd0, bus.ld_ready}, (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        bus.alu_valid = 1'b0;
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
